// File: rtl/alu_writeback_stage_pkg.sv
// Shared types for the ALU write-back path: opcode mnemonics and the write-back packet.
package alu_writeback_stage_pkg;

  localparam int W_DEF         = 8;
  localparam int REGW_DEF      = 3;
  localparam int CNTW_DEF      = 16;
  localparam int WB_SKID_DEPTH = 2;

  typedef enum logic [4:0] {
    ADD  = 5'd0,
    SUB  = 5'd1,
    AND  = 5'd2,
    OR   = 5'd3,
    XOR  = 5'd4,
    NOT  = 5'd5,
    SHL  = 5'd6,
    SHR  = 5'd7,
    INC  = 5'd8,
    DEC  = 5'd9,
    PASS = 5'd10
  } op_mne_t;

  typedef struct packed {
    logic [W_DEF-1:0]    data;
    logic [REGW_DEF-1:0] addr;
    logic                en;
  } wb_pkt_t;

  // Only a subtract defines a meaningful equality result for branches.
  function automatic logic op_sets_equal(input logic [4:0] op);
    return op == SUB;
  endfunction

endpackage

// File: rtl/alu_writeback_stage_wb_skid_buffer.sv
// Generic valid/ready buffer: DEPTH=1 is a single pass-through register,
// DEPTH>=2 adds a skid entry so in_ready comes straight from a flop.
module wb_skid_buffer
  import alu_writeback_stage_pkg::*;
#(
  parameter type pkt_t = wb_pkt_t,
  parameter int  DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  pkt_t in_pkt,
  output logic out_valid,
  input  logic out_ready,
  output pkt_t out_pkt
);

  logic out_free;
  assign out_free = !out_valid || out_ready;

  generate
    if (DEPTH >= 2) begin : g_skid
      logic skid_valid;
      pkt_t skid_pkt;
      logic in_fire;

      assign in_ready = !skid_valid;
      assign in_fire  = in_valid && in_ready;

      // Skid entry is always older than anything arriving, so it drains first.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid  <= 1'b0;
          out_pkt    <= '0;
          skid_valid <= 1'b0;
          skid_pkt   <= '0;
        end else if (out_free) begin
          if (skid_valid) begin
            out_valid  <= 1'b1;
            out_pkt    <= skid_pkt;
            skid_valid <= 1'b0;
          end else begin
            out_valid <= in_fire;
            if (in_fire) out_pkt <= in_pkt;
          end
        end else if (in_fire) begin
          skid_valid <= 1'b1;
          skid_pkt   <= in_pkt;
        end
      end
    end else begin : g_single
      assign in_ready = out_free;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          out_pkt   <= '0;
        end else if (out_free) begin
          out_valid <= in_valid;
          if (in_valid) out_pkt <= in_pkt;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU write-back stage: buffers results toward the register file, keeps branch flags
// and a retire counter. Define SKID_BUFFER_EN for the 2-entry skid buffer.
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int RegW = REGW_DEF,
  parameter int CntW = CNTW_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [4:0]      Operand,
  input  logic [W-1:0]    AluOut,
  input  logic            AluZero,
  input  logic            AluEqual,
  input  logic            WrEn,
  input  logic [RegW-1:0] WrAddr,
  output logic            WbValid,
  input  logic            WbReady,
  output logic [W-1:0]    WbData,
  output logic [RegW-1:0] WbAddr,
  output logic            WbEn,
  output logic            FlagZero,
  output logic            FlagEqual,
  output logic [CntW-1:0] RetireCnt
);

  // Same layout as wb_pkt_t, but sized from this instance's parameters.
  typedef struct packed {
    logic [W-1:0]    data;
    logic [RegW-1:0] addr;
    logic            en;
  } pkt_t;

`ifdef SKID_BUFFER_EN
  localparam int BUF_DEPTH = WB_SKID_DEPTH;
`else
  localparam int BUF_DEPTH = 1;
`endif

  pkt_t in_pkt, out_pkt;
  logic in_fire, out_fire;

  assign in_pkt   = '{data: AluOut, addr: WrAddr, en: WrEn};
  assign in_fire  = InValid && InReady;
  assign out_fire = WbValid && WbReady;

  wb_skid_buffer #(
    .pkt_t (pkt_t),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (Clk),
    .rst       (Reset),
    .in_valid  (InValid),
    .in_ready  (InReady),
    .in_pkt    (in_pkt),
    .out_valid (WbValid),
    .out_ready (WbReady),
    .out_pkt   (out_pkt)
  );

  assign WbData = out_pkt.data;
  assign WbAddr = out_pkt.addr;
  assign WbEn   = WbValid && out_pkt.en;

  // Flags track issue order, not retirement, so a branch sees them one cycle after accept.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      FlagZero  <= 1'b0;
      FlagEqual <= 1'b0;
    end else if (in_fire) begin
      FlagZero <= AluZero;
      if (op_sets_equal(Operand)) FlagEqual <= AluEqual;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)         RetireCnt <= '0;
    else if (out_fire) RetireCnt <= RetireCnt + 1'b1;
  end

endmodule
